// File: rtl/bcd_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_ctrl_pkg
// Description : Shared types and constants for the BCD timer controller:
//               FSM state encoding, BCD digit limits and a digit clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Out-of-range nibbles (A..F) saturate to 9 so digits stay valid BCD.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage : bcd_timer_ctrl_pkg
`default_nettype wire

// File: rtl/bcd_timer_ctrl_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One cascadable BCD up/down digit with synchronous load.
//               Ports: clk, rst (async, active-low), en (step this digit),
//               up_dn (1 = up), ld / ld_val (load, clamped to 9),
//               q (digit value), cy (carry/borrow into the next digit).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_timer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       cy
);

    logic [3:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= BCD_MIN;
        end else if (ld) begin
            r_q <= bcd_clamp(ld_val);
        end else if (en) begin
            if (up_dn)
                r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            else
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
        end
    end

    // Carry/borrow ripples combinationally so the whole counter steps on one edge.
    assign cy = en & (up_dn ? (r_q == BCD_MAX) : (r_q == BCD_MIN));
    assign q  = r_q;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_ctrl
// Description : Prescaled NDIG-digit BCD up/down timer with IDLE/RUN/PAUSE/DONE
//               control FSM.
//               Ports: clk, rst (async, active-low), load/load_val (preset),
//               start, stop, up_dn (1 = up), digits (BCD count, digit 0 in
//               [3:0]), running (FSM in RUN), done (FSM in DONE),
//               step (pulse in the cycle after a count step).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer_ctrl
    import bcd_timer_ctrl_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int NDIG     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              start,
    input  logic              stop,
    input  logic              up_dn,
    output logic [4*NDIG-1:0] digits,
    output logic              running,
    output logic              done,
    output logic              step
);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_RUN   = RUN;
    localparam logic [1:0] c_ST_PAUSE = PAUSE;
    localparam logic [1:0] c_ST_DONE  = DONE;
    localparam logic [7:0] c_PRE_LAST = 8'(PRESCALE - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_pre;
    logic        r_step;
    logic        w_step;
    logic [NDIG:0] w_en;       // w_en[i] steps digit i; w_en[NDIG] is the top carry
    logic        w_term_now;
    logic        w_term_after;

    // A step happens on the prescaler wrap, unless load or stop takes priority.
    assign w_step  = (r_state == c_ST_RUN) && !load && !stop && (r_pre == c_PRE_LAST);
    assign w_en[0] = w_step;

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .en     (w_en[i]),
                .up_dn  (up_dn),
                .ld     (load),
                .ld_val (load_val[4*i +: 4]),
                .q      (digits[4*i +: 4]),
                .cy     (w_en[i+1])
            );
        end
    endgenerate

    // w_term_now  : digits already terminal for the current direction.
    // w_term_after: the pending step lands on terminal, i.e. the count is
    //               one short of it (digit 0 at 8 up / 1 down, rest terminal).
    always_comb begin
        w_term_now   = 1'b1;
        w_term_after = (digits[3:0] == (up_dn ? 4'd8 : 4'd1));
        if (digits[3:0] != (up_dn ? BCD_MAX : BCD_MIN))
            w_term_now = 1'b0;
        for (int i = 1; i < NDIG; i++) begin
            if (digits[4*i +: 4] != (up_dn ? BCD_MAX : BCD_MIN)) begin
                w_term_now   = 1'b0;
                w_term_after = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_pre   <= 8'd0;
            r_step  <= 1'b0;
        end else begin
            r_step <= w_step;
            if (load) begin
                r_state <= c_ST_IDLE;
                r_pre   <= 8'd0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!stop && start) begin
                            r_state <= w_term_now ? c_ST_DONE : c_ST_RUN;
                            r_pre   <= 8'd0;
                        end
                    end
                    c_ST_RUN: begin
                        if (stop) begin
                            r_state <= c_ST_PAUSE;  // prescaler held for resume
                        end else begin
                            r_pre <= (r_pre == c_PRE_LAST) ? 8'd0 : r_pre + 8'd1;
                            // Top carry cannot normally occur (terminal stops
                            // first) but is treated as terminal if it does.
                            if (w_step && (w_term_after || w_en[NDIG]))
                                r_state <= c_ST_DONE;
                        end
                    end
                    c_ST_PAUSE: begin
                        if (!stop && start)
                            r_state <= c_ST_RUN;
                    end
                    c_ST_DONE: begin
                        if (stop)
                            r_state <= c_ST_IDLE;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign running = (r_state == c_ST_RUN);
    assign done    = (r_state == c_ST_DONE);
    assign step    = r_step;

endmodule : bcd_timer_ctrl
`default_nettype wire

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4: clk cycles per count step, legal range 2..255.
REQ-002 The block SHALL have parameter NDIG, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port load, input, 1 bit: load load_val into the count and return to IDLE.
REQ-006 The block SHALL have port load_val, input, 4*NDIG bits: preset value, digit 0 in bits [3:0].
REQ-007 The block SHALL have port start, input, 1 bit: start counting, or resume from PAUSE.
REQ-008 The block SHALL have port stop, input, 1 bit: pause counting, or leave DONE.
REQ-009 The block SHALL have port up_dn, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-010 The block SHALL have port digits, output, 4*NDIG bits: current BCD count.
REQ-011 The block SHALL have port running, output, 1 bit: high while the FSM is in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: high while the FSM is in DONE.
REQ-013 The block SHALL have port step, output, 1 bit: one-cycle pulse in the cycle after digits changed by a count step.

Function
REQ-014 The FSM SHALL have four states (IDLE, RUN, PAUSE, DONE), all transitions on the rising edge of clk.
REQ-015 The control inputs SHALL have fixed priority when asserted together: load > stop > start.
REQ-016 Load SHALL be accepted in any state; digits take load_val next edge, the FSM goes to IDLE and the prescaler clears.
REQ-017 Any load_val digit greater than 9 SHALL load as 9.
REQ-018 In IDLE, start SHALL go to RUN with the prescaler at 0, unless digits are already terminal for up_dn; then it SHALL go straight to DONE.
REQ-019 Terminal count SHALL be all digits 9 when counting up and all digits 0 when counting down.
REQ-020 In RUN, the prescaler SHALL count 0..PRESCALE-1; each wrap to 0 produces one count step.
REQ-021 The first step SHALL appear on digits exactly PRESCALE cycles after the edge that entered RUN.
REQ-022 A step SHALL sample up_dn at the step edge only; a mid-period change of up_dn affects the next step.
REQ-023 Up step: digit i increments; 9 SHALL wrap to 0 and carry into digit i+1.
REQ-024 Down step: digit i decrements; 0 SHALL wrap to 9 and borrow from digit i+1.
REQ-025 A step that makes digits terminal SHALL move the FSM to DONE on that same edge; no further steps occur.
REQ-026 In RUN, stop SHALL go to PAUSE with the prescaler value held.
REQ-027 In PAUSE, start SHALL resume RUN from the held prescaler value.
REQ-028 In DONE, start SHALL be ignored; stop SHALL go to IDLE with digits held.
REQ-029 Digits SHALL change only on a step or a load.
REQ-030 Digits SHALL always hold valid BCD (each digit 0..9).

Reset
REQ-031 While rst is low, the block SHALL asynchronously force state IDLE, digits 0, prescaler 0, running 0, done 0, step 0.
REQ-032 A reset asserted mid-RUN SHALL abort the count with no partial step.
REQ-033 The first edge after rst deasserts SHALL evaluate inputs normally.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, RUN, PAUSE, DONE) and the constants BCD_MAX = 9 and BCD_MIN = 0.
REQ-035 The design SHALL use one sub-module, bcd_digit, instantiated NDIG times.
REQ-036 bcd_digit SHALL take clk, rst, en, up_dn, ld and ld_val, and output q[3:0] and cy.
REQ-037 bcd_digit SHALL assert cy when en is high and q is 9 (up) or 0 (down); digit i+1 en = digit i cy.
REQ-038 The FSM and prescaler SHALL reside in bcd_timer_ctrl.

Verification
REQ-039 The bench SHALL run all scenarios with PRESCALE=4 and NDIG=4.
REQ-040 Scenario: load 0x0098, up_dn=1, start -> digits 0x0099 four cycles after entering RUN, then 0x0100 four cycles later; step pulses each time.
REQ-041 Scenario: load 0x0003, up_dn=0, start -> digits step 0x0002, 0x0001, 0x0000; done rises on the 0x0000 edge; running falls on that same edge.
REQ-042 Scenario: RUN at 0x0050, stop asserted two cycles into a period, held 10 cycles, then start -> next step two cycles after resume; digits 0x0051.
REQ-043 Scenario: load, stop and start asserted together in RUN -> load wins; FSM in IDLE; digits equal load_val; load_val 0xFA3C loads as 0x9939.
REQ-044 Scenario: IDLE with digits 0x9999, up_dn=1, start -> DONE next edge with no step pulse; a further start is ignored; stop returns to IDLE with 0x9999 held.
REQ-045 Scenario: rst pulled low mid-period at 0x1234 -> digits 0x0000 and all flags 0 immediately; after release, start counts from 0x0000.
